branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined processor. It replaces static predict-not-taken fetch with a direct-mapped branch target buffer (BTB) that holds a 2-bit saturating counter per entry. Fetch performs a lookup each cycle. Decode reports resolved branches, jumps and `jr` back to the predictor, which updates the table and flags mispredictions so the pipeline can flush IF/ID and redirect the PC.

## Interface
- XLEN, 32, address/data width
- ENTRIES, 16, BTB entries; power of two, ≥ 2; IDX_W = log2(ENTRIES)
- CNT_W, 16, width of the mispredict statistics counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears table and statistics
- enable  in  1  pipeline enable; when low, no state changes
- lookup_pc  in  XLEN  fetch-stage PC
- pred_taken  out  1  prediction for lookup_pc
- pred_target  out  XLEN  predicted next PC for lookup_pc
- upd_valid  in  1  decode stage has a resolved control-flow instruction
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target
- upd_pred_taken  in  1  prediction made for it at fetch (carried through IF/ID)
- upd_pred_target  in  XLEN  predicted target carried through IF/ID
- mispredict  out  1  flush request for IF/ID
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- mispredict_count  out  CNT_W  saturating count of mispredictions

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[XLEN-1:IDX_W+2].
- Each entry holds valid, tag, ctr[1:0] and target[XLEN-1:0].
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational from registered state:
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : lookup_pc+4, with the addition modulo 2^XLEN.
- mispredict = upd_valid && !reset && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Update is written at the clock edge when upd_valid && enable:
  - Hit, taken: ctr increments, saturating at ST; target ← upd_target.
  - Hit, not taken: ctr decrements, saturating at SNT; entry stays valid.
  - Miss, taken: allocate the entry, replacing any aliased entry. valid=1, tag written, ctr=WT, target=upd_target.
  - Miss, not taken: no change.
- mispredict_count increments when mispredict && enable. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values: all valid=0, all ctr=WNT, all targets=0, mispredict_count=0.
- While reset is high: pred_taken=0, pred_target=lookup_pc+4, mispredict=0.
- Assertion of reset takes effect immediately and asynchronously, including mid-update. Release is synchronous to clk.
- Lookup latency is 0 cycles, combinational.
- An update becomes visible to lookup on the cycle after the edge that writes it.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update state, with no bypass.
- mispredict and redirect_pc are combinational and valid in the same cycle as upd_valid.
- enable=0: table and counter hold. The mispredict and redirect outputs are still driven, and the pipeline holds IF/ID.
- The counter updates once per enabled cycle. There is no handshake; upd_valid is a single-cycle qualifier.

## Structure
- Package bp_pkg holds:
  - the counter state constants SNT/WNT/WT/ST;
  - the functions sat_inc and sat_dec;
  - the entry struct type (valid, tag, ctr, target).
- Sub-module bp_sat_counter: a CNT_W-bit saturating incrementer with async reset, used for mispredict_count.
- The table is a flop array, written on one port and read combinationally on another. No SRAM macro.

## Test plan
All scenarios use ENTRIES=16 and CNT_W=4.

- **Reset state:** after reset, lookup_pc=0x40 → pred_taken=0, pred_target=0x44, mispredict_count=0.
- **Allocation:** update pc=0x40, taken, target=0x100, upd_pred_taken=0 → mispredict=1 and redirect_pc=0x100 in the same cycle. The next cycle, lookup 0x40 → pred_taken=1, pred_target=0x100, count=1.
- **Hysteresis:** entry 0x40 at WT, update not-taken → WNT and lookup pred_taken=0. A second not-taken → SNT, entry still valid. Then two taken updates → WT, pred_taken=1.
- **Aliasing and same-cycle read:**
  - Entry 0x40 valid; update 0x80, taken, target 0x200 (same index, different tag). The same-cycle lookup of 0x40 still hits (old state).
  - The next cycle, lookup 0x40 → pred_taken=0 and lookup 0x80 → pred_target=0x200.
  - A not-taken miss update on 0x3C0 leaves the table unchanged.
- **Enable and saturation:**
  - enable=0, upd_valid=1 with a mispredict → mispredict=1, but the table and count are unchanged.
  - 20 enabled mispredicts → mispredict_count=15 and holds.
- **Async reset:** assert reset between clock edges while entries are valid and count=7 → pred_taken=0 and count=0 immediately. After release, all lookups miss.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the dynamic branch predictor.
//   - 2-bit saturating counter states (SNT/WNT/WT/ST)
//   - sat_inc / sat_dec helpers for those counters
//   - bp_entry_t: one BTB entry (valid, tag, ctr, target)
// Tag and target fields are sized for the widest supported XLEN (BP_MAX_XLEN).
// Narrower configurations zero-extend into them, so the upper bits are
// constant and trimmed by synthesis. XLEN must not exceed BP_MAX_XLEN.
package bp_pkg;

  localparam int BP_MAX_XLEN = 64;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic [BP_MAX_XLEN-1:0] tag;
    logic [1:0]             ctr;
    logic [BP_MAX_XLEN-1:0] target;
  } bp_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears count to 0
//   inc    - increment request for this cycle
//   count  - current count value
module bp_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating counter per
// entry. Fetch looks up combinationally every cycle; decode reports resolved
// control flow, which updates the table and raises a flush request on a
// misprediction.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   enable                      - pipeline enable; gates all state changes
//   lookup_pc                   - fetch PC
//   pred_taken, pred_target     - prediction for lookup_pc
//   upd_valid, upd_pc,
//   upd_taken, upd_target       - resolved instruction and its outcome
//   upd_pred_taken,
//   upd_pred_target             - prediction made for it at fetch
//   mispredict, redirect_pc     - flush request and corrected next PC
//   mispredict_count            - saturating misprediction statistic
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};

  bp_entry_t table_reg [ENTRIES];

  // Tags are kept as the PC shifted down past index and byte-offset bits,
  // zero-extended, so the whole stored field takes part in the compare.
  logic [IDX_W-1:0]       lookup_idx;
  logic [BP_MAX_XLEN-1:0] lookup_tag;
  bp_entry_t              lookup_entry;
  logic                   lookup_hit;

  logic [IDX_W-1:0]       upd_idx;
  logic [BP_MAX_XLEN-1:0] upd_tag;
  bp_entry_t              upd_entry;
  logic                   upd_hit;

  logic                   wr_en;
  bp_entry_t              wr_entry;
  logic                   cnt_inc;

  assign lookup_idx   = lookup_pc[IDX_W+1:2];
  assign lookup_tag   = BP_MAX_XLEN'(lookup_pc >> (IDX_W + 2));
  assign lookup_entry = table_reg[lookup_idx];
  assign lookup_hit   = lookup_entry.valid && (lookup_entry.tag == lookup_tag);

  // The table is already cleared asynchronously; gating with reset also
  // covers the instant before that clear settles.
  assign pred_taken  = !reset && lookup_hit && lookup_entry.ctr[1];
  assign pred_target = pred_taken ? XLEN'(lookup_entry.target) : lookup_pc + XLEN'(4);

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = BP_MAX_XLEN'(upd_pc >> (IDX_W + 2));
  assign upd_entry = table_reg[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  assign mispredict  = upd_valid && !reset &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  // Next value of the indexed entry. A not-taken miss leaves the table alone
  // so that fall-through branches never evict useful entries.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (enable && upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_entry.ctr    = sat_inc(upd_entry.ctr);
          wr_entry.target = BP_MAX_XLEN'(upd_target);
        end else begin
          wr_entry.ctr = sat_dec(upd_entry.ctr);
        end
      end else if (upd_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: upd_tag, ctr: WT,
                     target: BP_MAX_XLEN'(upd_target)};
      end
    end
  end

  // Single write port; lookups read the registered array, so a same-cycle
  // lookup of the written index sees the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_reg[i] <= ENTRY_RESET;
      end
    end else if (wr_en) begin
      table_reg[upd_idx] <= wr_entry;
    end
  end

  assign cnt_inc = mispredict && enable;

  bp_sat_counter #(
    .W(CNT_W)
  ) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CNT_W=4).
// The driver applies one transaction per cycle shortly after the rising edge,
// computes the expected outputs from a table-level reference model and pushes
// them; the monitor pops and compares on the falling edge.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_count;

  branch_predictor #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: a table indexed by (pc/4) mod 16 ------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];   // 0..3, taken when >= 2
  logic [31:0] m_tgt   [ENTRIES];
  int          m_count;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_count = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int i;
    i  = m_idx(pc);
    pt = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    tgt = pt ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1;
      m_tag[i]   = m_tagof(pc);
      m_ctr[i]   = 2;
      m_tgt[i]   = tgt;
    end
  endtask

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    int          id;
    logic [31:0] lpc;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  task automatic chk(input int id, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", id, name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.id, "pred_taken", 32'(pred_taken), 32'(e.pt));
      chk(e.id, "pred_target", pred_target, e.ptg);
      chk(e.id, "mispredict", 32'(mispredict), 32'(e.mp));
      chk(e.id, "redirect_pc", redirect_pc, e.rd);
      chk(e.id, "mispredict_count", 32'(mispredict_count), 32'(e.cnt));
      $display("txn %0d rst=%0b en=%0b lpc=%08h pred=%0b/%08h upd=%0b pc=%08h mp=%0b rd=%08h cnt=%0d",
               e.id, reset, enable, e.lpc, pred_taken, pred_target, upd_valid, upd_pc,
               mispredict, redirect_pc, mispredict_count);
    end
  end

  // ---------------- driver --------------------------------------------------
  task automatic cycle(input logic rst, input logic en, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    enable          = en;
    lookup_pc       = lpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    if (rst) m_clear();
    e.id  = n_txn++;
    e.lpc = lpc;
    m_lookup(lpc, e.pt, e.ptg);
    e.mp  = uv && !rst && ((ut != upt) || (ut && utgt != uptgt));
    e.rd  = ut ? utgt : upc + 32'd4;
    e.cnt = m_count;
    sb.push_back(e);
    if (!rst && en) begin
      if (e.mp && m_count < CNT_MAX) m_count++;
      if (uv) m_update(upc, ut, utgt);
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(1'b0, 1'b1, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] upc;
    logic        ut;

    reset = 1'b1; enable = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    m_clear();

    // Reset state
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h40);
    idle(32'hFFFF_FFFC);                              // pc+4 wraps to 0

    // Allocation, then visible next cycle
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    idle(32'h40);

    // Hysteresis: WT -> WNT -> SNT -> WNT -> WT
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    idle(32'h40);

    // Aliasing with same-cycle lookup of the old entry
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    idle(32'h40);
    idle(32'h80);
    cycle(1'b0, 1'b1, 32'h80, 1'b1, 32'h3C0, 1'b0, 32'h0, 1'b0, 32'h3C4);
    idle(32'h80);

    // Enable low: outputs driven, no state change
    cycle(1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h200);
    idle(32'h80);

    // Saturation of the statistics counter
    for (int k = 0; k < 20; k++)
      cycle(1'b0, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
    idle(32'h80);

    // Async reset with valid entries and count=7, asserted mid-update
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++)
      cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h40 + 32'(k) * 4, 1'b1, 32'h1000 + 32'(k) * 16, 1'b0, 32'h0);
    idle(32'h40);
    cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 32'h2000, 1'b0, 32'h48);
    for (int k = 0; k < 7; k++) idle(32'h40 + 32'(k) * 4);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      upc = rand_pc();
      ut  = 1'($urandom_range(0, 1));
      m_lookup(upc, pt, ptg);
      if ($urandom_range(0, 4) == 0) pt = ~pt;
      if ($urandom_range(0, 6) == 0) ptg = $urandom & 32'hFFFF_FFFC;
      cycle(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 4) != 0), rand_pc(),
            1'($urandom_range(0, 3) != 0), upc, ut,
            32'($urandom_range(0, 3)) * 32'h100 + 32'($urandom_range(0, 15)) * 4,
            pt, ptg);
    end

    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
